// File: rtl/clkdiv_ctrl_pkg.sv
// Shared types and sizing helpers for the CLKDIV alignment sequencer.
package clkdiv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RESET  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_CALIB  = 3'd4,
        ST_LOCKED = 3'd5,
        ST_FAIL   = 3'd6
    } state_t;

    localparam int DEF_RST_CYCLES    = 4;
    localparam int DEF_SETTLE_CYCLES = 8;
    localparam int DEF_CHECK_CYCLES  = 4;
    localparam int DEF_MAX_CALIB     = 3;
    localparam int DEF_LOSS_CYCLES   = 16;

    // Bits needed to hold values 0..max_value, never less than one.
    function automatic int cnt_width(input int max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

    function automatic int timer_width(input int rst_cycles, input int settle_cycles);
        int max_load;
        max_load = (rst_cycles > settle_cycles) ? rst_cycles - 1 : settle_cycles - 1;
        return cnt_width(max_load);
    endfunction

endpackage

// File: rtl/clkdiv_align_ctrl_if.sv
// Bring-up handshake and CLKDIV pin bundle; slave = sequencer, master = bring-up logic.
interface clkdiv_align_ctrl_if
    import clkdiv_ctrl_pkg::*;
#(
    parameter int MAX_CALIB = DEF_MAX_CALIB
);
    localparam int CW = cnt_width(MAX_CALIB);

    logic          start;
    logic          align_ok;
    logic          clkdiv_resetn;
    logic          clkdiv_calib;
    logic          busy;
    logic          locked;
    logic          fail;
    logic [CW-1:0] calib_count;

    modport master (
        output start, align_ok,
        input  clkdiv_resetn, clkdiv_calib, busy, locked, fail, calib_count
    );

    modport slave (
        input  start, align_ok,
        output clkdiv_resetn, clkdiv_calib, busy, locked, fail, calib_count
    );

endinterface

// File: rtl/clkdiv_ctrl_timer.sv
// Loadable down-counter that stops at zero; zero flag is decoded from the count register.
module clkdiv_ctrl_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/clkdiv_align_ctrl.sv
// Reset/settle/check/calibrate sequencer for one CLKDIV primitive, all outputs registered.
// Optional auto-relock on sustained alignment loss: define CLKDIV_ALIGN_RELOCK_EN.
module clkdiv_align_ctrl
    import clkdiv_ctrl_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int CHECK_CYCLES  = DEF_CHECK_CYCLES,
    parameter int MAX_CALIB     = DEF_MAX_CALIB
`ifdef CLKDIV_ALIGN_RELOCK_EN
    , parameter int LOSS_CYCLES = DEF_LOSS_CYCLES
`endif
) (
    input  logic                clk,
    input  logic                rst,
    clkdiv_align_ctrl_if.slave  bus
);

    localparam int TW = timer_width(RST_CYCLES, SETTLE_CYCLES);
    localparam int CW = cnt_width(MAX_CALIB);
    localparam int GW = cnt_width(CHECK_CYCLES);

    state_t        state;
    logic          resetn_q;
    logic          calib_q;
    logic          busy_q;
    logic          locked_q;
    logic          fail_q;
    logic [CW-1:0] calib_cnt;
    logic [GW-1:0] good_cnt;

    logic          restart;
    logic          loss_trip;
    logic          t_load;
    logic [TW-1:0] t_value;
    logic          t_zero;

`ifdef CLKDIV_ALIGN_RELOCK_EN
    localparam int LW = cnt_width(LOSS_CYCLES);
    logic [LW-1:0] loss_cnt;

    assign loss_trip = (state == ST_LOCKED) && !bus.align_ok
                       && (loss_cnt == LW'(LOSS_CYCLES - 1));
`else
    assign loss_trip = 1'b0;
`endif

    // A start is honoured only outside the busy window; a relock reuses the same entry path.
    always_comb begin
        // NOTE: defaulting every always_comb output first keeps the block free of inferred latches.
        restart = 1'b0;
        if (bus.start && (state == ST_IDLE || state == ST_LOCKED || state == ST_FAIL)) begin
            restart = 1'b1;
        end
        if (loss_trip) begin
            restart = 1'b1;
        end
    end

    always_comb begin
        t_load  = 1'b0;
        t_value = TW'(RST_CYCLES - 1);
        if (restart) begin
            t_load  = 1'b1;
            t_value = TW'(RST_CYCLES - 1);
        end else if ((state == ST_RESET && t_zero) || state == ST_CALIB) begin
            t_load  = 1'b1;
            t_value = TW'(SETTLE_CYCLES - 1);
        end
    end

    clkdiv_ctrl_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (t_load),
        .load_value (t_value),
        .zero       (t_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            resetn_q  <= 1'b0;
            calib_q   <= 1'b0;
            busy_q    <= 1'b0;
            locked_q  <= 1'b0;
            fail_q    <= 1'b0;
            calib_cnt <= '0;
            good_cnt  <= '0;
`ifdef CLKDIV_ALIGN_RELOCK_EN
            loss_cnt  <= '0;
`endif
        end else if (restart) begin
            state     <= ST_RESET;
            resetn_q  <= 1'b0;
            calib_q   <= 1'b0;
            busy_q    <= 1'b1;
            locked_q  <= 1'b0;
            fail_q    <= 1'b0;
            calib_cnt <= '0;
        end else begin
            calib_q <= 1'b0;
            case (state)
                ST_RESET: begin
                    if (t_zero) begin
                        state    <= ST_SETTLE;
                        resetn_q <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (t_zero) begin
                        state    <= ST_CHECK;
                        good_cnt <= '0;
                    end
                end
                ST_CHECK: begin
                    if (bus.align_ok) begin
                        if (good_cnt == GW'(CHECK_CYCLES - 1)) begin
                            state    <= ST_LOCKED;
                            busy_q   <= 1'b0;
                            locked_q <= 1'b1;
`ifdef CLKDIV_ALIGN_RELOCK_EN
                            loss_cnt <= '0;
`endif
                        end else begin
                            good_cnt <= good_cnt + GW'(1);
                        end
                    end else if (calib_cnt < CW'(MAX_CALIB)) begin
                        state   <= ST_CALIB;
                        calib_q <= 1'b1;
                    end else begin
                        state  <= ST_FAIL;
                        busy_q <= 1'b0;
                        fail_q <= 1'b1;
                    end
                end
                ST_CALIB: begin
                    state <= ST_SETTLE;
                    if (calib_cnt < CW'(MAX_CALIB)) begin
                        calib_cnt <= calib_cnt + CW'(1);
                    end
                end
                ST_LOCKED: begin
`ifdef CLKDIV_ALIGN_RELOCK_EN
                    // Any good sample forgives earlier misses; only an unbroken run trips relock.
                    if (bus.align_ok) begin
                        loss_cnt <= '0;
                    end else begin
                        loss_cnt <= loss_cnt + LW'(1);
                    end
`endif
                end
                ST_IDLE, ST_FAIL: begin
                end
                default: begin
                    state    <= ST_IDLE;
                    resetn_q <= 1'b0;
                    busy_q   <= 1'b0;
                    locked_q <= 1'b0;
                    fail_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.clkdiv_resetn = resetn_q;
    assign bus.clkdiv_calib  = calib_q;
    assign bus.busy          = busy_q;
    assign bus.locked        = locked_q;
    assign bus.fail          = fail_q;
    assign bus.calib_count   = calib_cnt;

endmodule

// File: tb/tb_clkdiv_align_ctrl.sv
// Directed bench for clkdiv_align_ctrl at default parameters; edge k=1 is the edge sampling start.
module tb_clkdiv_align_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    clkdiv_align_ctrl_if bus ();

    clkdiv_align_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int   lock_at;
        int   fail_at;
        int   pulses;
        int   p1;
        int   p2;
        int   rn_rise;
        int   busy_drop;
        logic first_busy;
        logic first_locked;
        logic first_fail;
        logic first_resetn;
    } seq_res_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulses start, then samples n_cycles negedges; align_ok goes high after sample ok_from
    // (0 = high from the start), and start is re-pulsed after sample start_again_at (0 = never).
    task automatic run_seq(input int n_cycles, input int ok_from, input int start_again_at,
                           output seq_res_t r);
        r = '{default: 0};
        @(negedge clk);
        bus.start    = 1'b1;
        bus.align_ok = (ok_from <= 0);
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 1; k <= n_cycles; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 1) begin
                r.first_busy   = bus.busy;
                r.first_locked = bus.locked;
                r.first_fail   = bus.fail;
                r.first_resetn = bus.clkdiv_resetn;
            end
            if (bus.locked && r.lock_at == 0) r.lock_at = k;
            if (bus.fail && r.fail_at == 0) r.fail_at = k;
            if (bus.clkdiv_resetn && r.rn_rise == 0) r.rn_rise = k;
            if (!bus.busy && r.busy_drop == 0) r.busy_drop = k;
            if (bus.clkdiv_calib) begin
                r.pulses++;
                if (r.pulses == 1) r.p1 = k;
                if (r.pulses == 2) r.p2 = k;
            end
            if (ok_from > 0 && k >= ok_from) bus.align_ok = 1'b1;
            bus.start = (k == start_again_at);
        end
        bus.start = 1'b0;
    endtask

    initial begin
        seq_res_t r;
        int       w;
        int       seen;

        bus.start    = 1'b0;
        bus.align_ok = 1'b0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_resetn", bus.clkdiv_resetn, 0);
        check("rst_calib",  bus.clkdiv_calib,  0);
        check("rst_busy",   bus.busy,          0);
        check("rst_locked", bus.locked,        0);
        check("rst_fail",   bus.fail,          0);
        check("rst_count",  bus.calib_count,   0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_busy",   bus.busy,          0);
        check("idle_resetn", bus.clkdiv_resetn, 0);

        // Clean lock: 4 reset cycles, 8 settle, 4 good samples.
        run_seq(30, 0, 0, r);
        check("c1_first_busy",   r.first_busy,   1);
        check("c1_first_resetn", r.first_resetn, 0);
        check("c1_resetn_rise",  r.rn_rise,      5);
        check("c1_lock_at",      r.lock_at,      17);
        check("c1_busy_drop",    r.busy_drop,    17);
        check("c1_pulses",       r.pulses,       0);
        check("c1_count",        bus.calib_count, 0);
        check("c1_fail",         bus.fail,       0);

        // Two calibrations, then alignment holds after the second settle.
        run_seq(45, 24, 0, r);
        check("c2_first_locked", r.first_locked, 0);
        check("c2_pulses",       r.pulses,       2);
        check("c2_p1",           r.p1,           14);
        check("c2_spacing",      r.p2 - r.p1,    10);
        check("c2_lock_at",      r.lock_at,      37);
        check("c2_count",        bus.calib_count, 2);
        check("c2_locked",       bus.locked,     1);

        // Never aligns: three pulses, then fail.
        run_seq(70, 1000, 0, r);
        check("c3_pulses",    r.pulses,        3);
        check("c3_fail_at",   r.fail_at,       44);
        check("c3_busy_drop", r.busy_drop,     44);
        check("c3_lock_at",   r.lock_at,       0);
        check("c3_count",     bus.calib_count, 3);
        check("c3_fail",      bus.fail,        1);
        check("c3_busy",      bus.busy,        0);
        check("c3_resetn",    bus.clkdiv_resetn, 1);

        // Restart from FAIL; a start during SETTLE must not disturb the sequence.
        run_seq(30, 0, 8, r);
        check("c4_first_fail", r.first_fail, 0);
        check("c4_count_clr",  bus.calib_count, 0);
        check("c4_lock_at",    r.lock_at, 17);
        check("c4_rn_rise",    r.rn_rise, 5);

        // Start while LOCKED drops lock on the next edge and reruns the whole sequence.
        run_seq(25, 0, 0, r);
        check("c4b_first_locked", r.first_locked, 0);
        check("c4b_first_resetn", r.first_resetn, 0);
        check("c4b_first_busy",   r.first_busy,   1);
        check("c4b_lock_at",      r.lock_at,      17);

        // Reset on the edge that would enter CALIB: no pulse, everything at reset values.
        run_seq(13, 1000, 0, r);
        check("c5_pre_busy", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("c5_calib",  bus.clkdiv_calib,  0);
        check("c5_resetn", bus.clkdiv_resetn, 0);
        check("c5_busy",   bus.busy,          0);
        check("c5_locked", bus.locked,        0);
        check("c5_fail",   bus.fail,          0);
        check("c5_count",  bus.calib_count,   0);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.clkdiv_calib) seen++;
        end
        check("c5_no_pulse", seen, 0);
        check("c5_idle",     bus.busy, 0);

        // Alignment loss while LOCKED.
        run_seq(20, 0, 0, r);
        check("c6_lock_at", r.lock_at, 17);
        bus.align_ok = 1'b0;
        repeat (15) @(negedge clk);
        bus.align_ok = 1'b1;
        check("c6_loss15_locked", bus.locked, 1);
        @(negedge clk);
        bus.align_ok = 1'b0;
        repeat (16) @(negedge clk);
`ifdef CLKDIV_ALIGN_RELOCK_EN
        check("c6_loss16_locked", bus.locked,        0);
        check("c6_loss16_resetn", bus.clkdiv_resetn, 0);
        check("c6_loss16_busy",   bus.busy,          1);
        bus.align_ok = 1'b1;
        w = 0;
        while (!bus.locked && w < 40) begin
            @(negedge clk);
            w++;
        end
        check("c6_relock_latency", w, 16);
`else
        check("c6_loss16_locked", bus.locked,        1);
        check("c6_loss16_resetn", bus.clkdiv_resetn, 1);
        check("c6_loss16_busy",   bus.busy,          0);
        repeat (30) @(negedge clk);
        w = 0;
        check("c6_hold_locked", bus.locked, 1);
        check("c6_hold_busy",   bus.busy,   0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
